// File: rtl/alu_multdiv_seq.sv
// alu_multdiv_seq: 32-bit signed multiply (radix-2 Booth) and divide (restoring)
// sequencer that iterates the shared combinational ALU one step per cycle.
module alu_multdiv_seq #(
   parameter logic [4:0] ADD_OP = 5'b00000,
   parameter logic [4:0] SUB_OP = 5'b00001
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   output logic [4:0]  alu_opcode,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
   state_t      state_q, state_d;
   // hi holds U (multiply) or R (divide); lo holds L or Q; op holds M or D
   logic [31:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d, res_q, res_d;
   logic        bit_q, bit_d, neg_q, neg_d, exc_q, exc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rp, abs_a, abs_b;
   logic        borrow, t;

   assign rp     = {hi_q[30:0], lo_q[31]};
   assign t      = alu_result[31] ^ alu_overflow;
   assign borrow = (~rp[31] & op_q[31]) | (~(rp[31] ^ op_q[31]) & alu_result[31]);
   assign abs_a  = data_operandA[31] ? -data_operandA : data_operandA;
   assign abs_b  = data_operandB[31] ? -data_operandB : data_operandB;

   always_ff @(posedge clock)
      if (!reset_n) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
         bit_q   <= 1'b0;
         neg_q   <= 1'b0;
         exc_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         res_q   <= res_d;
         bit_q   <= bit_d;
         neg_q   <= neg_d;
         exc_q   <= exc_d;
         cnt_q   <= cnt_d;
      end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      res_d   = res_q;
      bit_d   = bit_q;
      neg_d   = neg_q;
      exc_d   = exc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (ctrl_MULT) begin
               state_d = MUL;
               hi_d    = '0;
               lo_d    = data_operandA;
               op_d    = data_operandB;
               bit_d   = 1'b0;
               cnt_d   = '0;
            end else if (ctrl_DIV && data_operandB == '0) begin
               state_d = DONE;
               res_d   = '0;
               exc_d   = 1'b1;
            end else if (ctrl_DIV) begin
               state_d = DIV;
               hi_d    = '0;
               lo_d    = abs_a;
               op_d    = abs_b;
               neg_d   = data_operandA[31] ^ data_operandB[31];
               cnt_d   = '0;
            end
         end
         MUL: begin
            hi_d  = {t, alu_result[31:1]};
            lo_d  = {alu_result[0], lo_q[31:1]};
            bit_d = lo_q[0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
               res_d   = lo_d;
               exc_d   = hi_d != {32{lo_d[31]}};
            end
         end
         DIV: begin
            hi_d  = borrow ? rp : alu_result;
            lo_d  = {lo_q[30:0], ~borrow};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            res_d   = neg_q ? alu_result : lo_q;
            exc_d   = lo_q[31] & ~neg_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      alu_operandA = '0;
      alu_operandB = '0;
      alu_opcode   = ADD_OP;
      case (state_q)
         MUL: begin
            alu_operandA = hi_q;
            alu_operandB = (lo_q[0] ^ bit_q) ? op_q : '0;
            alu_opcode   = (lo_q[0] & ~bit_q) ? SUB_OP : ADD_OP;
         end
         DIV: begin
            alu_operandA = rp;
            alu_operandB = op_q;
            alu_opcode   = SUB_OP;
         end
         FIX: begin
            alu_operandB = lo_q;
            alu_opcode   = SUB_OP;
         end
         default: ;
      endcase
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = state_q == DONE;
   assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// tb_alu_multdiv_seq: scoreboard bench with a behavioural ALU; expected result,
// exception and completion cycle are queued at each accepted start.
module tb_alu_multdiv_seq;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] alu_operandA, alu_operandB, alu_result, data_result;
   logic [4:0]  alu_opcode;
   logic        alu_overflow, data_exception, data_resultRDY, busy;

   typedef struct {logic [31:0] res; logic exc; int at;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_chk = 0, n_fail = 0;

   alu_multdiv_seq dut (
      .clock(clock), .reset_n(reset_n),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   assign alu_result   = (alu_opcode == 5'b00001) ? alu_operandA - alu_operandB : alu_operandA + alu_operandB;
   assign alu_overflow = (alu_opcode == 5'b00001)
                       ? (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31])
                       : (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      logic [63:0] p;
      pa = $signed(a);
      pb = $signed(b);
      p  = pa * pb;
      return {p[63:32] != {32{p[31]}}, p[31:0]};
   endfunction

   function automatic logic [32:0] div_ref(input logic [31:0] a, input logic [31:0] b);
      int x, y, q;
      if (b == '0) return {1'b1, 32'h0};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, a};
      x = $signed(a);
      y = $signed(b);
      q = x / y;
      return {1'b0, 32'(q)};
   endfunction

   always @(negedge clock)
      if (reset_n && data_resultRDY) begin
         if (sb.size() == 0) check("spurious_rdy", 1, 0);
         else begin
            mon_e = sb.pop_front();
            check("result", data_result, mon_e.res);
            check("exception", data_exception, mon_e.exc);
            check("rdy_cycle", cyc, mon_e.at);
         end
      end

   // called at a negedge; the start edge is the following posedge
   task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      logic [32:0] r;
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = m;
      ctrl_DIV = d;
      if (push) begin
         r = m ? mul_ref(a, b) : div_ref(a, b);
         e.res = r[31:0];
         e.exc = r[32];
         e.at = cyc + 1 + (m ? 32 : (b == '0 ? 0 : 33));
         sb.push_back(e);
      end
      @(posedge clock);
      #1 ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clock);
      if (sb.size() != 0) begin
         check("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      start(m, !m, a, b, 1'b1);
      @(negedge clock);
      check("busy_after_start", busy, 1);
      wait_idle();
   endtask

   typedef struct {bit m; logic [31:0] a; logic [31:0] b;} op_t;
   op_t ops[$] = '{
      '{1'b1, 32'd7,        32'hFFFFFFFA},
      '{1'b1, 32'h00010000, 32'h00010000},
      '{1'b1, 32'h80000000, 32'd1},
      '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{1'b0, 32'hFFFFFF9C, 32'd7},
      '{1'b0, 32'h7FFFFFFF, 32'd2},
      '{1'b0, 32'd5,        32'd0},
      '{1'b0, 32'h80000000, 32'hFFFFFFFF},
      '{1'b0, 32'h80000000, 32'd1},
      '{1'b0, 32'h80000000, 32'h80000000},
      '{1'b0, 32'd7,        32'hFFFFFF9C}
   };

   initial begin
      int k;
      logic [31:0] ra, rb;
      repeat (3) @(negedge clock);
      check("reset_result", data_result, 0);
      check("reset_exc", data_exception, 0);
      check("reset_rdy", data_resultRDY, 0);
      check("reset_busy", busy, 0);
      reset_n = 1'b1;
      foreach (ops[i]) run_op(ops[i].m, ops[i].a, ops[i].b);
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(0, 10)) - 32'd5 : $urandom;
         run_op(i % 2 == 0, ra, rb);
      end
      // both starts high: multiply wins; a later divide pulse is ignored
      @(negedge clock);
      start(1'b1, 1'b1, 32'd3, 32'd4, 1'b1);
      repeat (4) @(negedge clock);
      start(1'b0, 1'b1, 32'd100, 32'd0, 1'b0);
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!data_resultRDY && k < 100);
      check("rdy_seen", data_resultRDY, 1);
      start(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
      @(negedge clock);
      check("busy_after_done_start", busy, 1);
      check("rdy_cleared", data_resultRDY, 0);
      wait_idle();
      // reset in the middle of a multiply aborts it
      @(negedge clock);
      start(1'b1, 1'b0, 32'd9, 32'd9, 1'b1);
      repeat (9) @(negedge clock);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clock);
      check("abort_busy", busy, 0);
      check("abort_rdy", data_resultRDY, 0);
      check("abort_result", data_result, 0);
      check("abort_exc", data_exception, 0);
      reset_n = 1'b1;
      repeat (50) @(negedge clock);
      run_op(1'b0, 32'd100, 32'hFFFFFFF9);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_multdiv_seq.md
Name: alu_multdiv_seq

Overview:
- Sequencer that performs 32-bit signed multiply and divide by iterating the processor's shared combinational ALU.
- The ALU provides add/sub, an overflow flag and a 32-bit result. This block drives the ALU operands and opcode, and captures the ALU result every cycle.
- It sits beside the ALU in the execute stage and is started by single-cycle ctrl_MULT / ctrl_DIV pulses.
- Multiply uses radix-2 Booth (32 iterations). Divide uses restoring division on magnitudes, followed by a sign-fix cycle.

Parameters:
ADD_OP, 5'b00000, ALU opcode for A+B
SUB_OP, 5'b00001, ALU opcode for A-B

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
data_operandA  input  32  multiplicand / dividend, sampled at start
data_operandB  input  32  multiplier / divisor, sampled at start
ctrl_MULT  input  1  start-multiply pulse
ctrl_DIV  input  1  start-divide pulse
alu_operandA  output  32  combinational drive to ALU operand A
alu_operandB  output  32  combinational drive to ALU operand B
alu_opcode  output  5  combinational drive to ALU opcode
alu_result  input  32  ALU result, same cycle
alu_overflow  input  1  ALU signed overflow, same cycle
data_result  output  32  product low word or quotient, registered
data_exception  output  1  overflow / divide-by-zero, registered
data_resultRDY  output  1  one-cycle completion strobe
busy  output  1  high from the cycle after start through the RDY cycle

Behaviour:
- Interface: single clock named clock; reset_n is synchronous and active-low.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal registers are cleared.
  - Reset during an operation aborts it; no RDY is ever produced for the aborted operation.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE.
  - If ctrl_MULT and ctrl_DIV are both high, MULT wins.
  - Starts while in MUL/DIV/FIX are ignored.
  - Accepting a start clears data_resultRDY; data_exception is updated at RDY.
  - Operands are latched at the start edge T.
- ALU usage:
  - The ALU is combinational. alu_* outputs derive only from state registers; alu_result and alu_overflow are sampled at the next edge.
  - In IDLE/DONE: alu_operandA=0, alu_operandB=0, alu_opcode=ADD_OP.
- Multiply (Booth):
  - Registers: U[31:0]=0, L=A, q=0, M=B, cnt.
  - Each MUL cycle:
    - If {L[0],q}=01: drive U+M (ADD_OP).
    - If {L[0],q}=10: drive U-M (SUB_OP).
    - Otherwise: drive U+0.
  - With S = alu_result and the true sign t = S[31]^alu_overflow, the arithmetic right shift is {U,L,q} <= {t, S[31:0], L} >> 1, i.e. U={t,S[31:1]}, L={S[0],L[31:1]}, q=L[0].
  - After exactly 32 MUL cycles (T+1..T+32) go to DONE.
  - data_result=L; data_exception=1 iff U != {32{L[31]}}.
  - RDY is high in cycle T+33.
- Divide:
  - If B==0 at start: go to DONE directly, data_result=0, data_exception=1, RDY at T+1.
  - Otherwise latch |A| into Q, |B| into D, R=0, and neg=A[31]^B[31].
  - Each DIV cycle:
    - Form R' = {R[30:0],Q[31]} and drive R' - D (SUB_OP).
    - Compute the unsigned borrow from the ALU: borrow = (~R'[31]&D[31]) | (~(R'[31]^D[31])&alu_result[31]).
    - If !borrow: R=alu_result, Q={Q[30:0],1}.
    - Else: R=R', Q={Q[30:0],0}.
  - 32 DIV cycles (T+1..T+32), then FIX at T+33.
  - FIX: drive 0 - Q (SUB_OP). Result = neg ? alu_result : Q.
  - data_exception=1 iff Q[31]==1 && !neg (only -2^31 / -1).
  - RDY is high in cycle T+34.
  - Quotient truncates toward zero; the remainder is discarded.
- DONE:
  - Lasts one cycle with data_resultRDY=1, then returns to IDLE.
  - data_result and data_exception hold until the next accepted start's completion.
- Magnitude rules:
  - |x| for x=0x80000000 is 0x80000000, treated as unsigned.
  - R never exceeds 2^31-1 before a shift.

Test Plan:
- Multiply 7 × -6: pulse ctrl_MULT at T -> busy T+1..T+33; RDY only at T+33; data_result=0xFFFFFFD6; exception=0.
- Multiply 0x00010000 × 0x00010000 -> data_result=0x00000000, exception=1. Multiply 0x80000000 × 1 -> 0x80000000, exception=0.
- Divide -100 / 7 -> RDY at T+34, data_result=0xFFFFFFF2 (-14), exception=0. Divide 0x7FFFFFFF / 2 -> 0x3FFFFFFF.
- Divide 5 / 0 -> RDY at T+1, data_result=0, exception=1. Divide 0x80000000 / 0xFFFFFFFF -> exception=1. Divide 0x80000000 / 1 -> 0x80000000, exception=0.
- ctrl_MULT and ctrl_DIV both high at T with A=3, B=4 -> multiply runs, result 12 at T+33. ctrl_DIV pulsed at T+5 is ignored. A new start accepted in the DONE cycle begins immediately.
- reset_n=0 at T+10 of a multiply -> next cycle busy=0, RDY=0, data_result=0. No RDY ever appears for the aborted operation.
